calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencer in front of the combinational ALU (8-bit A/B, 2-bit OP_CODE, 16-bit RESULT, NEG).
- Accepts a three-beat operand/opcode transaction over a valid/ready input stream and presents A, B and OP_CODE to the ALU.
- Waits a programmable settle time, captures RESULT/NEG into output registers, and holds them on a valid/ready output stream until consumed.
- Sits between the calculator input logic (keypad/host) and the display/result consumer.

Parameters:
- DW, 8: operand width. ALU result width is 2*DW.
- SETTLE, 1: cycles the ALU inputs are held stable before capture. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  controller can accept a beat.
- in_data  in  DW  beat payload: beat0 = A, beat1 = B, beat2 = opcode in bits [1:0], upper bits ignored.
- abort  in  1  synchronous cancel of the current transaction.
- alu_a  out  DW  to ALU A.
- alu_b  out  DW  to ALU B.
- alu_op  out  2  to ALU OP_CODE.
- alu_result  in  2*DW  from ALU RESULT.
- alu_neg  in  1  from ALU NEG.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  2*DW  captured result.
- out_neg  out  1  captured NEG.
- out_err  out  1  opcode 2'b11 (reserved) was issued.
- op_count  out  8  completed transactions, wraps 255 -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = GET_A.
  - alu_a, alu_b, alu_op, out_result, out_neg, out_err, out_valid, op_count = 0.
  - in_ready = 0 while reset is asserted.
- FSM states: GET_A, GET_B, GET_OP, EXEC, DONE.
- in_ready = 1 only in GET_A, GET_B and GET_OP. A beat transfers when in_valid && in_ready at a clock edge.
- GET_A: on transfer, alu_a <= in_data, go to GET_B.
- GET_B: on transfer, alu_b <= in_data, go to GET_OP.
- GET_OP: on transfer, alu_op <= in_data[1:0], load the settle counter with SETTLE-1, go to EXEC.
- EXEC:
  - alu_a, alu_b and alu_op are held stable.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: out_result <= alu_result, out_neg <= alu_neg, out_err <= (alu_op == 2'b11), out_valid <= 1, go to DONE.
  - Latency, with SETTLE=1: the opcode beat is accepted at edge N and out_valid rises after edge N+1. In general, out_valid rises SETTLE edges after the opcode beat.
  - Reserved opcode 2'b11: out_result and out_neg are forced to 0 instead of captured, and out_err = 1.
- DONE:
  - out_result, out_neg and out_err are held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: out_valid <= 0, op_count <= op_count + 1 (8-bit wrap), go to GET_A.
  - in_ready = 0, so a new transaction never overlaps an unconsumed result.
- alu_* outputs are not cleared between transactions. They keep their last values until overwritten by the next beats.
- abort:
  - In GET_B, GET_OP or EXEC: go to GET_A at the next edge. No capture, op_count unchanged, out_* unchanged.
  - Priority: abort wins over a simultaneous in_valid beat or settle completion.
  - In GET_A: no effect.
  - In DONE: ignored. The result must still be consumed.
- Reset asserted mid-transaction or in DONE: immediate return to the reset values. The pending result is lost.
- out_ready is ignored when out_valid = 0.
- in_valid is ignored when in_ready = 0.

Test Plan:
- Basic op:
  - Stimulus: SETTLE=1, stub ALU returns {A,B} with NEG=A[7]. Beats A=8'hC2, B=8'hF6, op=2'b00 on consecutive cycles, out_ready=1.
  - Required: out_valid rises one edge after the op beat with out_result=16'hC2F6, out_neg=1, out_err=0. out_valid drops the next edge. op_count=1.
- Back-pressure:
  - Stimulus: complete a transaction, hold out_ready=0 for 5 cycles, driving in_valid=1 with in_data=8'h55 throughout.
  - Required: in_ready=0, out_result stable, alu_a still 8'hC2. Releasing out_ready completes the handshake, then the next 8'h55 is accepted as A.
- Reserved opcode:
  - Stimulus: A=8'h12, B=8'h07, op=2'b11.
  - Required: out_valid with out_result=16'h0000, out_neg=0, out_err=1. op_count increments on consume.
- Settle timing:
  - Stimulus: SETTLE=4. Stub changes alu_result from 16'h0001 to 16'hBEEF three cycles after the op beat.
  - Required: captured result is 16'hBEEF, and out_valid rises exactly 4 edges after the op beat.
- Abort and reset:
  - Stimulus: abort in GET_OP together with in_valid.
  - Required: no capture, state returns to GET_A, op_count unchanged.
  - Stimulus: then drive reset=0 asynchronously mid-EXEC.
  - Required: all outputs 0 immediately, before the next clock edge.
- Counter wrap:
  - Stimulus: run 256 transactions.
  - Required: op_count goes 255 -> 0.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - operand/opcode sequencer in front of the combinational ALU
module calc_seq_ctrl #(
    parameter int DW     = 8,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              abort,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [1:0]        alu_op,
    input  logic [2*DW-1:0]   alu_result,
    input  logic              alu_neg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_result,
    output logic              out_neg,
    output logic              out_err,
    output logic [7:0]        op_count
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Counter is loaded with SETTLE-1 so that capture lands SETTLE edges after the opcode beat.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;

    // Beats are only accepted while collecting operands; held low during reset so
    // nothing upstream sees a spurious ready.
    assign in_ready = reset && ((state == GET_A) || (state == GET_B) || (state == GET_OP));

    // Transaction FSM: operand collection, settle wait, result capture and hand-off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= GET_A;
            settle_cnt <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 2'b00;
            out_result <= '0;
            out_neg    <= 1'b0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            case (state)
                GET_A: begin
                    // abort has nothing to cancel here, so the beat is taken normally
                    if (in_valid) begin
                        alu_a <= in_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (abort) begin
                        state <= GET_A;
                    end else if (in_valid) begin
                        alu_b <= in_data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (abort) begin
                        state <= GET_A;
                    end else if (in_valid) begin
                        alu_op     <= in_data[1:0];
                        settle_cnt <= SETTLE_LOAD;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (abort) begin
                        state <= GET_A;
                    end else if (settle_cnt == 4'd0) begin
                        // reserved opcode yields a clean zero result flagged as error
                        if (alu_op == 2'b11) begin
                            out_result <= '0;
                            out_neg    <= 1'b0;
                            out_err    <= 1'b1;
                        end else begin
                            out_result <= alu_result;
                            out_neg    <= alu_neg;
                            out_err    <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // abort is deliberately ignored: a produced result must be consumed
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= GET_A;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - scoreboard bench for calc_seq_ctrl with stub ALUs
module tb_calc_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic        n;
        logic        e;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- DUT with SETTLE=1 ----------------
    logic        rst1, iv1, ir1, ab1, neg1, ov1, or1, oneg1, oerr1;
    logic [7:0]  id1, a1, b1, cnt1;
    logic [1:0]  op1;
    logic [15:0] res1, ores1;

    // stub ALU: concatenation of operands offset by opcode, sign from A
    assign res1 = {a1, b1} + {14'd0, op1};
    assign neg1 = a1[7];

    calc_seq_ctrl #(.DW(8), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .abort(ab1), .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(res1),
        .alu_neg(neg1), .out_valid(ov1), .out_ready(or1), .out_result(ores1),
        .out_neg(oneg1), .out_err(oerr1), .op_count(cnt1)
    );

    // ---------------- DUT with SETTLE=4 ----------------
    logic        rst4, iv4, ir4, ab4, neg4, ov4, or4, oneg4, oerr4;
    logic [7:0]  id4, a4, b4, cnt4;
    logic [1:0]  op4;
    logic [15:0] res4, ores4;

    calc_seq_ctrl #(.DW(8), .SETTLE(4)) u_dut4 (
        .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .abort(ab4), .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_result(res4),
        .alu_neg(neg4), .out_valid(ov4), .out_ready(or4), .out_result(ores4),
        .out_neg(oneg4), .out_err(oerr4), .op_count(cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference behaviour of a completed transaction against the stub ALU
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        exp_t e;
        if (op == 2'b11) begin
            e.r = 16'h0000; e.n = 1'b0; e.e = 1'b1;
        end else begin
            e.r = {a, b} + 16'(op); e.n = a[7]; e.e = 1'b0;
        end
        return e;
    endfunction

    exp_t sb[$];
    int   ready_mode = 1;   // 0 random, 1 always ready, 2 stalled
    int   consumed   = 0;
    bit   hold_prev  = 0;
    exp_t held;

    // monitor: drives out_ready, checks hold stability and pops on each handshake
    initial begin
        or1 = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       or1 = ($urandom_range(0, 9) < 7);
                1:       or1 = 1'b1;
                default: or1 = 1'b0;
            endcase
            if (hold_prev) begin
                chk("hold_result", ores1, held.r);
                chk("hold_neg", oneg1, held.n);
                chk("hold_err", oerr1, held.e);
            end
            if (ov1 && or1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", ov1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_result", ores1, e.r);
                    chk("out_neg", oneg1, e.n);
                    chk("out_err", oerr1, e.e);
                    chk("op_count", cnt1, 32'(consumed[7:0]));
                    consumed++;
                end
            end
            hold_prev = ov1 && !or1;
            held = '{r: ores1, n: oneg1, e: oerr1};
        end
    end

    task automatic beat1(input logic [7:0] d, input logic ab_flag, input bit a_beat);
        int waited = 0;
        @(negedge clk);
        iv1 = 1'b1; id1 = d; ab1 = ab_flag;
        while (!ir1 && waited < 200) begin
            // abort while a result is pending must be ignored
            if (a_beat) ab1 = ov1 && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            waited++;
        end
        // abort in GET_A must not block the A beat
        if (a_beat) ab1 = ($urandom_range(0, 3) == 0);
        chk("in_ready_wait", ir1, 1);
        @(posedge clk); #1;
        iv1 = 1'b0; ab1 = 1'b0;
    endtask

    // mode: 0 complete, 1 abort with B beat, 2 abort with opcode beat, 3 abort in EXEC
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           input int mode, input int idle);
        logic [5:0] up;
        up = 6'($urandom);
        beat1(a, 1'b0, 1'b1);
        repeat (idle) @(posedge clk);
        if (mode == 1) begin
            beat1(b, 1'b1, 1'b0);
            return;
        end
        beat1(b, 1'b0, 1'b0);
        repeat (idle) @(posedge clk);
        if (mode == 2) begin
            beat1({up, op}, 1'b1, 1'b0);
            return;
        end
        beat1({up, op}, 1'b0, 1'b0);
        if (mode == 3) begin
            ab1 = 1'b1;
            @(posedge clk); #1;
            ab1 = 1'b0;
        end else begin
            sb.push_back(model(a, b, op));
        end
    endtask

    task automatic beat4(input logic [7:0] d);
        @(negedge clk);
        iv4 = 1'b1; id4 = d;
        chk("dut4_in_ready", ir4, 1);
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int waited;
        rst1 = 1'b0; iv1 = 1'b0; ab1 = 1'b0; id1 = 8'h00;
        rst4 = 1'b0; iv4 = 1'b0; ab4 = 1'b0; id4 = 8'h00;
        or4 = 1'b0; res4 = 16'h0001; neg4 = 1'b1;
        #3;
        chk("rst_in_ready", ir1, 0);
        chk("rst_out_valid", ov1, 0);
        chk("rst_alu_a", a1, 0);
        chk("rst_alu_b", b1, 0);
        chk("rst_alu_op", op1, 0);
        chk("rst_out_result", ores1, 0);
        chk("rst_out_neg", oneg1, 0);
        chk("rst_out_err", oerr1, 0);
        chk("rst_op_count", cnt1, 0);
        @(negedge clk); rst1 = 1'b1; rst4 = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", ir1, 1);

        // basic op with latency check
        beat1(8'hC2, 1'b0, 1'b0);
        beat1(8'hF6, 1'b0, 1'b0);
        beat1(8'h00, 1'b0, 1'b0);
        sb.push_back(model(8'hC2, 8'hF6, 2'b00));
        @(posedge clk); #1;
        chk("basic_valid_rise", ov1, 1);
        @(posedge clk); #1;
        chk("basic_valid_drop", ov1, 0);
        chk("basic_op_count", cnt1, 1);

        // reserved opcode held under back-pressure while new beats are offered
        ready_mode = 2;
        run_txn(8'h12, 8'h07, 2'b11, 0, 0);
        @(posedge clk); #1;
        chk("bp_valid", ov1, 1);
        repeat (5) begin
            @(negedge clk);
            iv1 = 1'b1; id1 = 8'h55;
            #1;
            chk("bp_in_ready", ir1, 0);
            chk("bp_alu_a", a1, 8'h12);
            chk("bp_out_valid", ov1, 1);
        end
        @(posedge clk); #1;
        ready_mode = 1;
        beat1(8'h55, 1'b0, 1'b0);
        chk("bp_next_a", a1, 8'h55);
        beat1(8'h01, 1'b0, 1'b0);
        beat1(8'h02, 1'b0, 1'b0);
        sb.push_back(model(8'h55, 8'h01, 2'b10));

        // randomized traffic, long enough to wrap op_count
        ready_mode = 0;
        for (int i = 0; i < 320; i++) begin
            int sel;
            int mode;
            sel = $urandom_range(0, 9);
            mode = (sel < 3) ? sel + 1 : 0;
            run_txn(8'($urandom), 8'($urandom), 2'($urandom), mode, $urandom_range(0, 2));
        end

        ready_mode = 1;
        waited = 0;
        while ((sb.size() != 0 || ov1) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        chk("final_op_count", cnt1, 32'(consumed[7:0]));

        // settle timing on the SETTLE=4 instance
        beat4(8'h11);
        beat4(8'h22);
        res4 = 16'h0001;
        beat4(8'h00);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("settle_valid_edge%0d", k), ov4, (k == 4) ? 1 : 0);
            if (k == 3) res4 = 16'hBEEF;
        end
        chk("settle_result", ores4, 16'hBEEF);
        chk("settle_neg", oneg4, 1);
        chk("settle_err", oerr4, 0);
        res4 = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("settle_hold", ores4, 16'hBEEF);
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        chk("settle_consumed", ov4, 0);
        chk("settle_op_count", cnt4, 1);

        // asynchronous reset in the middle of EXEC
        beat4(8'h33);
        beat4(8'h44);
        beat4(8'h01);
        @(posedge clk); #1;
        chk("mid_exec_not_valid", ov4, 0);
        #2 rst4 = 1'b0;
        #1;
        chk("async_alu_a", a4, 0);
        chk("async_alu_b", b4, 0);
        chk("async_alu_op", op4, 0);
        chk("async_out_result", ores4, 0);
        chk("async_out_neg", oneg4, 0);
        chk("async_op_count", cnt4, 0);
        chk("async_in_ready", ir4, 0);
        chk("async_out_valid", ov4, 0);
        @(negedge clk); rst4 = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
